// File: rtl/hazard_unit_pkg.sv
// Shared MIPS decode constants, bypass encodings and default MD latencies.
// Pulled into every hazard-unit file with import mips_defs::*.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // M beats W; a load sitting in M has no data yet, so m_ok masks it.
  function automatic logic [1:0] fwd_pick(
    input logic       rd_en,
    input logic [4:0] src,
    input logic [4:0] dm,
    input logic       m_ok,
    input logic [4:0] dw
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rd_en && src != 5'd0) begin
      if (m_ok && dm == src)
        sel = FWD_M;
      else if (dw == src)
        sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_instr_class.sv
// Per-stage instruction classifier: which fields are read, what is
// written, and whether it touches the multiply/divide unit.
module instr_class
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output logic        reads_rs,
  output logic        reads_rt,
  output logic [4:0]  dest,
  output logic        is_load,
  output logic        is_branch_jr,
  output logic        is_md_start,
  output logic        is_md_any
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       r_type;
  logic       unused_ok;

  assign op        = instr[31:26];
  assign funct     = instr[5:0];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign r_type    = (op == OP_RTYPE);
  assign unused_ok = ^instr[10:6];

  always_comb begin
    reads_rs     = 1'b0;
    reads_rt     = 1'b0;
    dest         = 5'd0;
    is_load      = 1'b0;
    is_branch_jr = 1'b0;
    is_md_start  = 1'b0;
    is_md_any    = 1'b0;
    unique case (1'b1)
      r_type && (funct == F_ADDU || funct == F_SUBU): begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
        dest     = rd;
      end
      r_type && funct == F_JR: begin
        reads_rs     = 1'b1;
        is_branch_jr = 1'b1;
      end
      r_type && (funct == F_MULT || funct == F_MULTU ||
                 funct == F_DIV  || funct == F_DIVU): begin
        reads_rs    = 1'b1;
        reads_rt    = 1'b1;
        is_md_start = 1'b1;
        is_md_any   = 1'b1;
      end
      r_type && (funct == F_MFHI || funct == F_MFLO): begin
        dest      = rd;
        is_md_any = 1'b1;
      end
      r_type && (funct == F_MTHI || funct == F_MTLO): begin
        reads_rs  = 1'b1;
        is_md_any = 1'b1;
      end
      op == OP_ORI: begin
        reads_rs = 1'b1;
        dest     = rt;
      end
      op == OP_LUI: begin
        dest = rt;
      end
      op == OP_LW: begin
        reads_rs = 1'b1;
        dest     = rt;
        is_load  = 1'b1;
      end
      op == OP_SW: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      op == OP_BEQ: begin
        reads_rs     = 1'b1;
        reads_rt     = 1'b1;
        is_branch_jr = 1'b1;
      end
      op == OP_JAL: begin
        dest = 5'd31;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall and bypass control for the 5-stage MIPS pipeline, including the
// HI/LO busy tracker for the multi-cycle multiply/divide unit.
module hazard_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic [31:0] instrE,
  input  logic [31:0] instrM,
  input  logic [31:0] instrW,
  output logic        stall,
  output logic [1:0]  fwd_rsD,
  output logic [1:0]  fwd_rtD,
  output logic [1:0]  fwd_rsE,
  output logic [1:0]  fwd_rtE,
  output logic        md_busy
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

  logic [31:0] ins [4];
  logic [3:0]  rrs;
  logic [3:0]  rrt;
  logic [3:0]  ld;
  logic [3:0]  br;
  logic [3:0]  mds;
  logic [3:0]  mda;
  logic [4:0]  dst [4];

  assign ins[0] = instrD;
  assign ins[1] = instrE;
  assign ins[2] = instrM;
  assign ins[3] = instrW;

  for (genvar s = 0; s < 4; s++) begin : g_cls
    instr_class u_cls (
      .instr        (ins[s]),
      .reads_rs     (rrs[s]),
      .reads_rt     (rrt[s]),
      .dest         (dst[s]),
      .is_load      (ld[s]),
      .is_branch_jr (br[s]),
      .is_md_start  (mds[s]),
      .is_md_any    (mda[s])
    );
  end

  logic unused_ok;
  assign unused_ok = ^{rrs[3:2], rrt[3:2], dst[0], ld[0], ld[3],
                       br[3:1], mds[0], mds[3:2], mda[3:1]};

  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] rsE;
  logic [4:0] rtE;
  assign rsD = instrD[25:21];
  assign rtD = instrD[20:16];
  assign rsE = instrE[25:21];
  assign rtE = instrE[20:16];

  logic m_ok;
  assign m_ok = ~ld[2];

  assign fwd_rsD = fwd_pick(rrs[0], rsD, dst[2], m_ok, dst[3]);
  assign fwd_rtD = fwd_pick(rrt[0], rtD, dst[2], m_ok, dst[3]);
  assign fwd_rsE = fwd_pick(rrs[1], rsE, dst[2], m_ok, dst[3]);
  assign fwd_rtE = fwd_pick(rrt[1], rtE, dst[2], m_ok, dst[3]);

  logic hitE;
  logic hitM;
  logic load_use;
  logic br_haz;
  logic md_haz;

  assign hitE = dst[1] != 5'd0 &&
                ((rrs[0] && rsD == dst[1]) || (rrt[0] && rtD == dst[1]));
  assign hitM = dst[2] != 5'd0 &&
                ((rrs[0] && rsD == dst[2]) || (rrt[0] && rtD == dst[2]));

  assign load_use = ld[1] && hitE;
  assign br_haz   = br[0] && (hitE || (ld[2] && hitM));
  assign md_haz   = mda[0] && (mds[1] || md_busy);
  assign stall    = load_use || br_haz || md_haz;

  // funct bit 1 separates div/divu (0x1A/0x1B) from mult/multu (0x18/0x19).
  logic [CW-1:0] md_cnt;

  always_ff @(posedge clk) begin
    if (!reset)
      md_cnt <= '0;
    else if (mds[1])
      md_cnt <= instrE[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

  assign md_busy = (md_cnt != '0);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: load-use, bypass priority,
// branch hazards, MD busy windows and reset behaviour.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrD;
  logic [31:0] instrE;
  logic [31:0] instrM;
  logic [31:0] instrW;
  logic        stall;
  logic [1:0]  fwd_rsD;
  logic [1:0]  fwd_rtD;
  logic [1:0]  fwd_rsE;
  logic [1:0]  fwd_rtE;
  logic        md_busy;

  int n_vec = 0;
  int n_err = 0;

  hazard_unit dut (
    .clk     (clk),
    .reset   (reset),
    .instrD  (instrD),
    .instrE  (instrE),
    .instrM  (instrM),
    .instrW  (instrW),
    .stall   (stall),
    .fwd_rsD (fwd_rsD),
    .fwd_rtD (fwd_rtD),
    .fwd_rsE (fwd_rsE),
    .fwd_rtE (fwd_rtE),
    .md_busy (md_busy)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] LW2    = 32'h8C02_0000;
  localparam logic [31:0] ADDU32 = 32'h0042_1821;
  localparam logic [31:0] ORI1   = 32'h3401_0005;
  localparam logic [31:0] ADDU41 = 32'h0020_2021;
  localparam logic [31:0] BEQ10  = 32'h1020_0003;
  localparam logic [31:0] ADDU1  = 32'h0043_0821;
  localparam logic [31:0] LW1    = 32'h8C01_0000;
  localparam logic [31:0] MULT   = 32'h0022_0018;
  localparam logic [31:0] DIV    = 32'h0022_001A;
  localparam logic [31:0] MFLO5  = 32'h0000_2812;
  localparam logic [31:0] LW0    = 32'h8C00_0000;
  localparam logic [31:0] ADDU30 = 32'h0000_1821;
  localparam logic [31:0] LUI41  = 32'h3C24_0000;
  localparam logic [31:0] JR31   = 32'h03E0_0008;
  localparam logic [31:0] JAL    = 32'h0C00_0000;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [31:0] d, input logic [31:0] e,
                     input logic [31:0] m, input logic [31:0] w);
    @(negedge clk);
    instrD = d;
    instrE = e;
    instrM = m;
    instrW = w;
    #1;
  endtask

  // Start an MD op in E with mflo held in D; the stall bubbles E each edge.
  task automatic md_run(input logic [31:0] op, input string tag,
                        input int exp_st, input int exp_bs);
    int st;
    int bs;
    bit done;
    st = 0;
    bs = 0;
    done = 0;
    put(MFLO5, op, 32'h0, 32'h0);
    for (int i = 0; i < 40 && !done; i++) begin
      if (stall) st++;
      if (md_busy) bs++;
      if (!stall) done = 1;
      else begin
        @(posedge clk);
        #1 instrE = 32'h0;
        @(negedge clk);
        #1;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall_len"}, 32'(st), 32'(exp_st));
    chk({tag, "_busy_len"}, 32'(bs), 32'(exp_bs));
  endtask

  initial begin
    reset  = 1'b0;
    instrD = '0;
    instrE = '0;
    instrM = '0;
    instrW = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    put(0, 0, 0, 0);
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    put(ADDU32, LW2, 0, 0);
    chk("lu_stall", 32'(stall), 32'd1);
    put(ADDU32, 0, LW2, 0);
    chk("lu_bubble_stall", 32'(stall), 32'd0);
    chk("lu_m_load_nofwd", 32'(fwd_rsD), 32'd0);
    put(0, ADDU32, 0, LW2);
    chk("lu_w_rs", 32'(fwd_rsE), 32'd2);
    chk("lu_w_rt", 32'(fwd_rtE), 32'd2);

    put(0, ADDU41, ORI1, 0);
    chk("m_rs", 32'(fwd_rsE), 32'd1);
    chk("m_rt", 32'(fwd_rtE), 32'd0);
    chk("m_stall", 32'(stall), 32'd0);
    put(0, ADDU41, ORI1, ORI1);
    chk("m_over_w", 32'(fwd_rsE), 32'd1);
    put(0, ADDU41, 0, ORI1);
    chk("w_only", 32'(fwd_rsE), 32'd2);
    put(0, LUI41, ORI1, 0);
    chk("lui_no_read", 32'(fwd_rsE), 32'd0);

    put(BEQ10, ADDU1, 0, 0);
    chk("br_e_stall", 32'(stall), 32'd1);
    put(BEQ10, 0, LW1, 0);
    chk("br_mlw_stall", 32'(stall), 32'd1);
    put(BEQ10, 0, ORI1, 0);
    chk("br_mori_stall", 32'(stall), 32'd0);
    chk("br_rsD", 32'(fwd_rsD), 32'd1);
    chk("br_rtD", 32'(fwd_rtD), 32'd0);
    put(JR31, JAL, 0, 0);
    chk("jr_jal_stall", 32'(stall), 32'd1);

    put(ADDU30, LW0, 0, 0);
    chk("r0_stall", 32'(stall), 32'd0);
    chk("r0_fwd", {24'h0, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE}, 32'h0);

    md_run(MULT, "mult", 6, 5);
    md_run(DIV, "div", 11, 10);

    put(0, DIV, 0, 0);
    @(posedge clk);
    #1 instrE = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt7_busy", 32'(md_busy), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    chk("mid_rst_busy", 32'(md_busy), 32'd0);
    put(MFLO5, 0, 0, 0);
    chk("mflo_idle_stall", 32'(stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard-detection and forwarding controller for the five-stage MIPS pipeline. It decodes the instructions currently held in D, E, M and W. It drives the `stall` input of the ID/EX register, which bubbles E, and the freeze of PC and IF/ID. It also drives the bypass-mux selects for D-stage comparisons and E-stage ALU operands. It tracks the multi-cycle multiply/divide unit with an internal busy counter, so `mfhi`/`mflo`/`mult`/`div` issue is held off until HI/LO are valid.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles after a mult/multu leaves E.
- `DIV_CYCLES`, 10: busy cycles after a div/divu leaves E.

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `instrD`  in  32  instruction in ID.
- `instrE`  in  32  instruction in EX.
- `instrM`  in  32  instruction in MEM.
- `instrW`  in  32  instruction in WB; 0 = bubble.
- `stall`  out  1  freeze PC and IF/ID, bubble ID/EX.
- `fwd_rsD`  out  2  bypass select for D-stage rs (branch/jr compare).
- `fwd_rtD`  out  2  bypass select for D-stage rt (branch/jr compare).
- `fwd_rsE`  out  2  bypass select for E-stage rs (ALU operand).
- `fwd_rtE`  out  2  bypass select for E-stage rt (ALU operand).
- `md_busy`  out  1  multiply/divide unit still computing.

## Operation
- Supported set: addu, subu, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, ori, lui, lw, sw, beq, jal. Any other encoding, including 0 (`sll $0`), is treated as a nop: no read, no write, no MD use.
- Field extraction: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
- Destination register:
  - rd for addu/subu/mfhi/mflo.
  - rt for ori/lui/lw.
  - 31 for jal.
  - none otherwise.
  - A destination of 0 is treated as none.
- Forward encoding: 0 = register file, 1 = M-stage result, 2 = W-stage result.
- Forwarding selection:
  - M wins over W when both match.
  - M is a forwarding source only if it is a non-load writer; lw data comes from W only.
  - Forwarding applies only when the field is actually read by that instruction class. Otherwise the select is 0.
- Stall conditions (OR of the following):
  - Load-use: E is lw, dest≠0, and D reads rs or rt equal to it.
  - Branch/jr in D: E writes rs/rt of D (any writer), or M is lw writing rs/rt of D.
  - MD: D is any MD-class instruction and (E is mult/multu/div/divu, or `md_busy`).
- Busy counter (`md_cnt`, width ≥ clog2(DIV_CYCLES+1)):
  - Load priority: E is mult/multu → load MULT_CYCLES; E is div/divu → load DIV_CYCLES.
  - Otherwise decrement if nonzero.
  - `md_busy` = (`md_cnt` ≠ 0).
  - A load while nonzero overwrites (reload wins).
- Reset (reset=0): `md_cnt`←0 on that edge. `md_busy`=0 afterwards, and `stall` is then a pure function of the instructions. All forward selects are combinational and have no reset value.

## Timing
- `stall` and all `fwd_*` are combinational from the instr inputs and registered `md_cnt`; they are valid in the same cycle with zero latency.
- `md_busy` is registered: it rises on the edge that captures the MD start in E and stays high for exactly MULT_CYCLES / DIV_CYCLES cycles.
- MD stall length for an MD instruction in D directly behind mult in E: 1 + MULT_CYCLES = 6 cycles; behind div: 1 + DIV_CYCLES = 11 cycles.
- While `stall`=1, E receives a bubble next edge, so `instrE` becomes 0. This bubble does not reload the counter.
- Reset asserted mid-count clears the counter on that edge. The next cycle shows `md_busy`=0.

## Structure
- Shared package `mips_defs`:
  - opcode/funct constants.
  - fwd encodings FWD_RF=0, FWD_M=1, FWD_W=2.
  - default cycle counts.
- One sub-module, `instr_class`, instantiated four times (D/E/M/W). Outputs: reads_rs, reads_rt, dest[4:0], is_load, is_branch_jr, is_md_start, is_md_any.
- The counter and stall/forward logic live in the top module.

## Test plan
- E=lw $2,0($0) 0x8C020000, D=addu $3,$2,$2 0x00421821 → stall=1. Next cycle, E=0, M=lw → stall=0. Following cycle, addu in E, lw in W → fwd_rsE=2, fwd_rtE=2.
- M=ori $1,$0,5 0x34010005, E=addu $4,$1,$0 0x00202021 → fwd_rsE=1, fwd_rtE=0, stall=0. When W=ori is also present with M=ori, M still wins (fwd_rsE=1).
- D=beq $1,$0 0x10200003: E=addu writing $1 → stall=1. M=lw $1 → stall=1. M=ori $1 → stall=0, fwd_rsD=1.
- E=mult $1,$2 0x00220018, D=mflo $5 0x00002812 held → stall high exactly 6 cycles, md_busy high 5. Same with div 0x0022001A → 11 and 10.
- Writes to $0: E=lw $0 0x8C000000, D=addu $3,$0,$0 → stall=0 and all fwd=0.
- reset=0 while md_cnt=7 → next cycle md_busy=0. D=mflo with no MD in E → stall=0.
